spi_frame_shifter: RTL and testbench
====================================

// Module: spi_frame_shifter
// PURPOSE
//  Serial frame engine downstream of the parameterised clock generator: consumes its
//  generated bit clock (sclk_i, a registered signal in the clk_i domain) and drives
//  its enable (gen_en_o). Shifts one DATA_W-bit word MSB-first out on mosi_o while
//  capturing miso_i, framed by cs_n_o. Used as the SPI core for Pmod DA/AD modules.
// PARAMETERS
//  DATA_W  16  frame length in bits (>=2)
//  CS_GAP  2   clk_i cycles cs_n_o stays high after a frame before a new start is accepted (>=1)
// PORTS
//  clk_i      in   1       system clock; all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  start_i    in   1       request a frame; accepted only when busy_o=0
//  data_i     in   DATA_W  TX word, latched on the accepted start cycle
//  sclk_i     in   1       bit clock from the clock generator
//  gen_en_o   out  1       enable for the clock generator
//  sclk_o     out  1       SPI clock to pad: sclk_i gated by state==SHIFT, else 0
//  cs_n_o     out  1       chip select, active low
//  mosi_o     out  1       serial data out = MSB of TX shift register
//  miso_i     in   1       serial data in
//  rx_data_o  out  DATA_W  last completed RX word
//  busy_o     out  1       high in SHIFT and GAP
//  done_o     out  1       one-cycle pulse at frame end
// BEHAVIOUR
//  Reset (async, immediate, also mid-frame): state=IDLE, cs_n_o=1, gen_en_o=0,
//   mosi_o=0, tx/rx shift regs=0, rx_data_o=0, bit_cnt=0, done_o=0, busy_o=0, sclk_d=0.
//  Edge detect: sclk_d <= sclk_i each cycle; rise = sclk_i & ~sclk_d; fall = ~sclk_i & sclk_d.
//   Edges act only in SHIFT; edges in IDLE/GAP are ignored.
//  bit_cnt width $clog2(DATA_W+1); gap counter width $clog2(CS_GAP+1).
//  IDLE: busy_o=0. start_i=1 -> next cycle: tx_sr<=data_i, bit_cnt<=0, cs_n_o<=0,
//   gen_en_o<=1, state SHIFT. mosi_o shows data_i[DATA_W-1] from the first SHIFT cycle.
//  SHIFT: gen_en_o=1, cs_n_o=0, busy_o=1.
//   - rise & bit_cnt<DATA_W: rx_sr <= {rx_sr[DATA_W-2:0], miso_i}; bit_cnt++.
//   - fall & 0<bit_cnt<DATA_W: tx_sr <= tx_sr<<1 (zero fill).
//   - fall & bit_cnt==0: ignored (sclk_i high on entry must not shift).
//   - fall & bit_cnt==DATA_W: rx_data_o<=rx_sr, done_o<=1 (one cycle), gen_en_o<=0,
//     cs_n_o<=1, mosi_o<=0, state GAP. sclk_i is low at this point, so sclk_o ends low.
//   - start_i ignored.
//  GAP: cs_n_o=1, gen_en_o=0, busy_o=1; count CS_GAP cycles then IDLE. start_i ignored.
//  Exactly DATA_W rising sclk_o edges per frame; mode 0 (CPOL=0, CPHA=0): data changes on
//   fall, sampled on rise. First-bit setup time = time from cs_n_o low to first rise.
//  start_i held high continuously: back-to-back frames separated by CS_GAP+1 idle cycles.
//  Latency start accept -> done_o depends only on sclk_i edges; no timeout.
//  rx_data_o holds until the next done_o.
// TESTING (DATA_W=8, CS_GAP=2, sclk_i from clock generator PERIOD=100, CLKPERIOD=10)
//  1 Loopback miso_i=mosi_o, start with data_i=8'hA5 -> 8 sclk_o rises, mosi bits
//    1,0,1,0,0,1,0,1 at rises, rx_data_o=8'hA5, single done_o pulse, sclk_o low at cs_n_o rise.
//  2 miso_i driven 8'h3C by bench model on falls, data_i=8'hFF -> rx_data_o=8'h3C.
//  3 start_i pulsed during SHIFT and during GAP -> ignored; no extra frame, data unchanged.
//  4 start_i held high, data_i=8'h01 then 8'h80 -> two frames, cs_n_o high >=3 cycles between.
//  5 rst asserted after 4th rise -> same cycle: cs_n_o=1, gen_en_o=0, busy_o=0, rx_data_o=0;
//    next start after release yields a clean full 8-bit frame.
//  6 bench drives sclk_i high at start (generator bypassed) -> first fall ignored,
//    still exactly 8 rises and correct 8'h5A loopback.

Source files
------------

// File: rtl/spi_frame_shifter.sv
// SPI mode-0 frame engine: shifts DATA_W bits MSB-first on the external bit clock and frames them with cs_n_o.
// Start-to-done latency follows sclk_i edges. Starts are accepted only when idle; frames cannot be stalled once running.
`timescale 1ns/1ps
module spi_frame_shifter #(
   parameter int DATA_W = 16,
   parameter int CS_GAP = 2
) (
   input  logic              clk_i,
   input  logic              rst,
   input  logic              start_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              sclk_i,
   output logic              gen_en_o,
   output logic              sclk_o,
   output logic              cs_n_o,
   output logic              mosi_o,
   input  logic              miso_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int BW = $clog2(DATA_W + 1);
   localparam int GW = $clog2(CS_GAP + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W);
   localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   logic [1:0]        state;
   logic              sclk_d;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [BW-1:0]     bit_cnt;
   logic [GW-1:0]     gap_cnt;
   logic              sclk_rise;
   logic              sclk_fall;

   assign sclk_rise = sclk_i & ~sclk_d;
   assign sclk_fall = ~sclk_i & sclk_d;
   assign sclk_o    = sclk_i & (state == ST_SHIFT);
   assign mosi_o    = tx_sr[DATA_W-1];
   assign busy_o    = (state != ST_IDLE);

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         sclk_d    <= 1'b0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         cs_n_o    <= 1'b1;
         gen_en_o  <= 1'b0;
         rx_data_o <= '0;
         done_o    <= 1'b0;
      end else begin
         sclk_d <= sclk_i;
         done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  tx_sr    <= data_i;
                  bit_cnt  <= '0;
                  cs_n_o   <= 1'b0;
                  gen_en_o <= 1'b1;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (sclk_rise && (bit_cnt < BIT_LAST)) begin
                  rx_sr   <= {rx_sr[DATA_W-2:0], miso_i};
                  bit_cnt <= bit_cnt + 1'b1;
               end else if (sclk_fall && (bit_cnt == BIT_LAST)) begin
                  rx_data_o <= rx_sr;
                  done_o    <= 1'b1;
                  gen_en_o  <= 1'b0;
                  cs_n_o    <= 1'b1;
                  tx_sr     <= '0;
                  gap_cnt   <= '0;
                  state     <= ST_GAP;
               end else if (sclk_fall && (bit_cnt != '0)) begin
                  // a fall before the first rise is the tail of a clock that was already high
                  tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state    <= ST_IDLE;
               cs_n_o   <= 1'b1;
               gen_en_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_shifter.sv
// Bench for spi_frame_shifter: clock-generator model, loopback/pattern slave model, per-frame scoreboard.
`timescale 1ns/1ps
module tb_spi_frame_shifter;

   localparam int DW  = 8;
   localparam int GAP = 2;

   logic          clk_i;
   logic          rst;
   logic          start_i;
   logic [DW-1:0] data_i;
   logic          sclk_i;
   logic          gen_en_o;
   logic          sclk_o;
   logic          cs_n_o;
   logic          mosi_o;
   logic          miso_i;
   logic [DW-1:0] rx_data_o;
   logic          busy_o;
   logic          done_o;

   logic          loopback;
   logic [DW-1:0] miso_pat;
   logic          preset_hi;

   int            n_checks;
   int            n_errors;

   // monitor state
   int            rise_cnt;
   int            fall_cnt;
   int            done_cnt;
   int            hi_run;
   int            last_gap;
   logic [31:0]   mosi_acc;
   logic          sclk_at_csrise;
   logic          p_sclk_o;
   logic          p_sclk_i;
   logic          p_csn;

   spi_frame_shifter #(.DATA_W(DW), .CS_GAP(GAP)) dut (
      .clk_i     (clk_i),
      .rst       (rst),
      .start_i   (start_i),
      .data_i    (data_i),
      .sclk_i    (sclk_i),
      .gen_en_o  (gen_en_o),
      .sclk_o    (sclk_o),
      .cs_n_o    (cs_n_o),
      .mosi_o    (mosi_o),
      .miso_i    (miso_i),
      .rx_data_o (rx_data_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   // slave: either echoes mosi, or presents the pattern MSB-first, advancing on each fall
   assign miso_i = loopback ? mosi_o : ((fall_cnt < DW) ? miso_pat[DW-1-fall_cnt] : 1'b0);

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // clock generator model: registered toggle every 5 clk_i cycles while enabled (100 ns period)
   initial begin
      int div;
      div    = 0;
      sclk_i = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         if (gen_en_o) begin
            div++;
            if (div == 5) begin
               div    = 0;
               sclk_i = ~sclk_i;
            end
         end else if (preset_hi) begin
            div    = 0;
            sclk_i = 1'b1;
         end else begin
            div    = 0;
            sclk_i = 1'b0;
         end
      end
   end

   initial begin
      rise_cnt       = 0;
      fall_cnt       = 0;
      done_cnt       = 0;
      hi_run         = 0;
      last_gap       = 0;
      mosi_acc       = '0;
      sclk_at_csrise = 1'b0;
      p_sclk_o       = 1'b0;
      p_sclk_i       = 1'b0;
      p_csn          = 1'b1;
      forever begin
         @(negedge clk_i);
         // a real bit-clock rise: sclk_o goes high because sclk_i itself rose
         if (sclk_o && !p_sclk_o && !p_sclk_i) begin
            rise_cnt++;
            mosi_acc = {mosi_acc[30:0], mosi_o};
         end
         if (!sclk_o && p_sclk_o) fall_cnt++;
         if (cs_n_o) begin
            if (!p_csn) sclk_at_csrise = sclk_o | p_sclk_o;
            hi_run++;
            fall_cnt = 0;
         end else begin
            if (p_csn) last_gap = hi_run;
            hi_run = 0;
         end
         if (done_o) done_cnt++;
         p_sclk_o = sclk_o;
         p_sclk_i = sclk_i;
         p_csn    = cs_n_o;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_frame(input string tag, input logic [DW-1:0] d, input logic [DW-1:0] pat,
                           input logic lb, input logic poke, input int rst_at);
      int            rb;
      int            db;
      int            n;
      logic [DW-1:0] exp_rx;
      exp_rx = lb ? d : pat;
      @(posedge clk_i);
      #1;
      data_i   = d;
      miso_pat = pat;
      loopback = lb;
      rb       = rise_cnt;
      db       = done_cnt;
      start_i  = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      chk({tag, "_cs_low"}, 32'(cs_n_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd1);
      chk({tag, "_mosi_first"}, 32'(mosi_o), 32'(d[DW-1]));
      if (poke) begin
         repeat (20) @(posedge clk_i);
         #1;
         start_i = 1'b1;
         data_i  = ~d;
         @(posedge clk_i);
         #1;
         start_i = 1'b0;
         data_i  = d;
      end
      n = 0;
      if (rst_at > 0) begin
         while ((rise_cnt - rb) < rst_at && n < 1000) begin
            @(negedge clk_i);
            #2;
            n++;
         end
         chk({tag, "_rise_wait"}, 32'(n < 1000), 32'd1);
         @(negedge clk_i);
         #2;
         rst = 1'b1;
         #1;
         chk({tag, "_rst_cs"}, 32'(cs_n_o), 32'd1);
         chk({tag, "_rst_gen"}, 32'(gen_en_o), 32'd0);
         chk({tag, "_rst_busy"}, 32'(busy_o), 32'd0);
         chk({tag, "_rst_rx"}, 32'(rx_data_o), 32'd0);
         chk({tag, "_rst_mosi"}, 32'(mosi_o), 32'd0);
         repeat (2) @(negedge clk_i);
         rst = 1'b0;
         repeat (3) @(posedge clk_i);
      end else begin
         while (!done_o && n < 1000) begin
            @(negedge clk_i);
            #2;
            n++;
         end
         chk({tag, "_done_seen"}, 32'(n < 1000), 32'd1);
         if (poke) begin
            start_i = 1'b1;
            data_i  = ~d;
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            data_i  = d;
         end
         repeat (6) @(posedge clk_i);
         #1;
         chk({tag, "_rx"}, 32'(rx_data_o), 32'(exp_rx));
         chk({tag, "_rises"}, 32'(rise_cnt - rb), 32'(DW));
         chk({tag, "_mosi_bits"}, 32'(mosi_acc[DW-1:0]), 32'(d));
         chk({tag, "_done_pulses"}, 32'(done_cnt - db), 32'd1);
         chk({tag, "_sclk_at_cs"}, 32'(sclk_at_csrise), 32'd0);
         chk({tag, "_idle"}, 32'(busy_o), 32'd0);
      end
   endtask

   initial begin
      int n;
      int db;
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      start_i   = 1'b0;
      data_i    = '0;
      loopback  = 1'b1;
      miso_pat  = '0;
      preset_hi = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset_cs", 32'(cs_n_o), 32'd1);
      chk("reset_gen", 32'(gen_en_o), 32'd0);
      chk("reset_busy", 32'(busy_o), 32'd0);
      chk("reset_done", 32'(done_o), 32'd0);
      chk("reset_rx", 32'(rx_data_o), 32'd0);
      chk("reset_mosi", 32'(mosi_o), 32'd0);
      chk("reset_sclk", 32'(sclk_o), 32'd0);
      @(negedge clk_i);
      rst = 1'b0;
      repeat (3) @(posedge clk_i);

      do_frame("loop_a5", 8'hA5, 8'h00, 1'b1, 1'b0, 0);
      do_frame("pat_3c", 8'hFF, 8'h3C, 1'b0, 1'b0, 0);
      do_frame("poke", 8'h69, 8'h00, 1'b1, 1'b1, 0);
      chk("hold_rx", 32'(rx_data_o), 32'h69);

      // start held high across two frames
      @(posedge clk_i);
      #1;
      db       = done_cnt;
      loopback = 1'b1;
      data_i   = 8'h01;
      start_i  = 1'b1;
      n = 0;
      while (cs_n_o && n < 100) begin @(negedge clk_i); #2; n++; end
      data_i = 8'h80;
      while (!done_o && n < 1000) begin @(negedge clk_i); #2; n++; end
      chk("b2b_rx1", 32'(rx_data_o), 32'h01);
      @(negedge clk_i);
      #2;
      while (cs_n_o && n < 1000) begin @(negedge clk_i); #2; n++; end
      start_i = 1'b0;
      chk("b2b_gap", 32'(last_gap), 32'(GAP + 1));
      while (!done_o && n < 2000) begin @(negedge clk_i); #2; n++; end
      chk("b2b_timeout", 32'(n < 2000), 32'd1);
      chk("b2b_rx2", 32'(rx_data_o), 32'h80);
      repeat (6) @(posedge clk_i);
      #1;
      chk("b2b_frames", 32'(done_cnt - db), 32'd2);
      chk("b2b_idle", 32'(busy_o), 32'd0);

      do_frame("rst_mid", 8'hC3, 8'h00, 1'b1, 1'b0, 4);
      do_frame("after_rst", 8'h96, 8'h00, 1'b1, 1'b0, 0);

      preset_hi = 1'b1;
      repeat (4) @(posedge clk_i);
      do_frame("sclk_hi", 8'h5A, 8'h00, 1'b1, 1'b0, 0);
      preset_hi = 1'b0;
      repeat (3) @(posedge clk_i);

      repeat (6) begin
         do_frame("rnd", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
